// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with frame-coherent snapshots,
// leading-zero blanking, per-digit decimal points and an inter-digit guard time.
`timescale 1ns/1ps
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic [3:0] dp_en,
    input  logic       blank_lz,
    output logic [7:0] SEG,
    output logic [3:0] DIGIT,
    output logic       frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [7:0] SEG_POL = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_POL = ACTIVE_LOW ? 4'hF : 4'h0;

    logic [PW-1:0] p;
    logic [1:0]    idx;
    logic [15:0]   snap_digits;
    logic [3:0]    snap_dp;
    logic          snap_lz;

    logic          slot_end;
    logic          frame_wrap;
    logic          in_guard;
    logic [3:0]    cur_nib;
    logic [3:0]    lz_mask;
    logic [6:0]    seg7;
    logic [7:0]    seg_next;
    logic [3:0]    digit_next;

    function automatic logic [6:0] decode_bcd(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end   = (p == P_LAST);
        frame_wrap = slot_end && (idx == 2'd3);
        in_guard   = (int'(p) < BLANK_CYCLES);
        cur_nib    = snap_digits[{idx, 2'b00} +: 4];

        // A digit is a leading zero only if it and every more significant digit are 0;
        // invalid nibbles are non-zero so they stop the blanking chain.
        lz_mask[3] = snap_lz && (snap_digits[15:12] == 4'd0);
        lz_mask[2] = lz_mask[3] && (snap_digits[11:8] == 4'd0);
        lz_mask[1] = lz_mask[2] && (snap_digits[7:4] == 4'd0);
        lz_mask[0] = 1'b0;

        seg7       = lz_mask[idx] ? 7'h00 : decode_bcd(cur_nib);
        seg_next   = {snap_dp[idx], seg7} ^ SEG_POL;
        digit_next = (in_guard ? 4'b0000 : (4'b0001 << idx)) ^ DIG_POL;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p           <= '0;
            idx         <= 2'd0;
            snap_digits <= 16'h0000;
            snap_dp     <= 4'h0;
            snap_lz     <= 1'b0;
            frame_done  <= 1'b0;
            SEG         <= SEG_POL;
            DIGIT       <= DIG_POL;
        end else begin
            SEG        <= seg_next;
            DIGIT      <= digit_next;
            frame_done <= frame_wrap;
            if (slot_end) begin
                p   <= '0;
                idx <= idx + 2'd1;
            end else begin
                p <= p + PW'(1);
            end
            // Inputs are sampled only here so a displayed frame is always coherent.
            if (frame_wrap) begin
                snap_digits <= {thousands, hundreds, tens, units};
                snap_dp     <= dp_en;
                snap_lz     <= blank_lz;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: time-based reference model plus directed
// display scenarios, random input traffic and asynchronous reset pulses.
`timescale 1ns/1ps
module tb_seg_scan_driver;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * SD;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] units, tens, hundreds, thousands, dp_en;
    logic       blank_lz;
    logic [7:0] seg;
    logic [3:0] digit;
    logic       frame_done;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .units     (units),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .dp_en     (dp_en),
        .blank_lz  (blank_lz),
        .SEG       (seg),
        .DIGIT     (digit),
        .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: m_* is the value captured so far, s_* is what the pins are showing.
    logic [3:0] m_dig [4];
    logic [3:0] s_dig [4];
    logic [3:0] m_dp, s_dp;
    logic       m_lz, s_lz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        units     = v[3:0];
        tens      = v[7:4];
        hundreds  = v[11:8];
        thousands = v[15:12];
        dp_en     = dp;
        blank_lz  = lz;
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = 4'h0;
            s_dig[i] = 4'h0;
        end
        m_dp = 4'h0;
        s_dp = 4'h0;
        m_lz = 1'b0;
        s_lz = 1'b0;
    endtask

    function automatic logic [7:0] exp_seg(input int slot);
        logic       blank;
        logic [7:0] ah;
        blank = 1'b0;
        if (s_lz && slot > 0) begin
            blank = 1'b1;
            for (int j = slot; j < 4; j++)
                if (s_dig[j] != 4'h0) blank = 1'b0;
        end
        ah = {s_dp[slot], blank ? 7'h00 : SEG_TAB[s_dig[slot]]};
        return ~ah;
    endfunction

    // One clock: update the model at the edge, compare all pins at the following negedge.
    task automatic step();
        int         s, slot, pos;
        logic [3:0] dexp;
        @(posedge clk);
        cyc++;
        s_dig = m_dig;
        s_dp  = m_dp;
        s_lz  = m_lz;
        if (cyc % FR == 0) begin
            m_dig[0] = units;
            m_dig[1] = tens;
            m_dig[2] = hundreds;
            m_dig[3] = thousands;
            m_dp     = dp_en;
            m_lz     = blank_lz;
        end
        @(negedge clk);
        s    = cyc - 1;
        slot = (s / SD) % 4;
        pos  = s % SD;
        dexp = (pos < BC) ? 4'hF : (4'hF ^ (4'b0001 << slot));
        check($sformatf("seg@%0d", cyc), seg, exp_seg(slot));
        check($sformatf("digit@%0d", cyc), digit, dexp);
        check($sformatf("frame_done@%0d", cyc), frame_done, (cyc % FR == 0));
    endtask

    task automatic wait_frame();
        do step(); while (cyc % FR != 0);
    endtask

    // Runs one whole frame; checks each slot's pattern and its 6-cycle enable window.
    task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input int chg_at, input logic [15:0] chg_v);
        logic [7:0] e [4];
        int on_cnt;
        e = '{e0, e1, e2, e3};
        for (int slot = 0; slot < 4; slot++) begin
            on_cnt = 0;
            for (int pos = 0; pos < SD; pos++) begin
                step();
                if (digit != 4'hF) on_cnt++;
                if (pos == SD - 1) check($sformatf("slot%0d_seg", slot), seg, e[slot]);
                if (chg_at == slot * SD + pos) set_in(chg_v, dp_en, blank_lz);
            end
            check($sformatf("slot%0d_on_cycles", slot), on_cnt, SD - BC);
        end
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #0.5;
        check("async_rst_seg", seg, 8'hFF);
        check("async_rst_digit", digit, 4'hF);
        check("async_rst_frame_done", frame_done, 1'b0);
        #0.5 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int fd_cnt;
        set_in(16'h0000, 4'h0, 1'b0);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("por_seg", seg, 8'hFF);
        check("por_digit", digit, 4'hF);
        check("por_frame_done", frame_done, 1'b0);
        #11 rst_n = 1'b1;

        // Reset in the middle of the tens slot, then scanning restarts at units showing 0.
        repeat (11) step();
        reset_pulse();
        step();
        check("restart_seg", seg, 8'hC0);
        check("restart_digit", digit, 4'hF);

        set_in(16'h1234, 4'h0, 1'b0);
        wait_frame();
        run_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, -1, 16'h0000);

        // Change mid-frame: current frame stays 1234, next frame shows 5678.
        run_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 12, 16'h5678);
        run_frame(8'h80, 8'hF8, 8'h82, 8'h92, -1, 16'h0000);

        set_in(16'h0007, 4'b0100, 1'b1);
        wait_frame();
        run_frame(8'hF8, 8'hFF, 8'h7F, 8'hFF, -1, 16'h0000);
        set_in(16'h0000, 4'b0000, 1'b1);
        wait_frame();
        run_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, -1, 16'h0000);

        set_in(16'h000C, 4'b0000, 1'b1);
        wait_frame();
        run_frame(8'hBF, 8'hFF, 8'hFF, 8'hFF, -1, 16'h0000);
        set_in(16'h00FC, 4'b0000, 1'b1);
        wait_frame();
        run_frame(8'hBF, 8'hBF, 8'hFF, 8'hFF, -1, 16'h0000);

        // Random traffic, including changes landing exactly on frame-wrap edges.
        repeat (10 * FR) begin
            if ($urandom_range(0, 5) == 0) begin
                logic [15:0] v;
                for (int i = 0; i < 4; i++)
                    v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                set_in(v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            step();
        end

        // Short reset pulse during the hundreds slot; next frame_done is 32 clocks later.
        wait_frame();
        repeat (17) step();
        reset_pulse();
        fd_cnt = 0;
        repeat (FR - 1) begin
            step();
            fd_cnt += int'(frame_done);
        end
        check("no_early_frame_done", fd_cnt, 0);
        step();
        check("frame_done_after_32", frame_done, 1'b1);
        repeat (FR) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
